// File: rtl/mem_access_unit_if.sv
// Bundle for the load/store front-end.
// Carries the pipeline request/response handshake and the data-RAM port.
//   master : the environment side, meaning the pipeline MEM stage plus the data RAM.
//            It drives the request, rsp_ready and ram_rd_data.
//   slave  : mem_access_unit. It drives req_ready, the response and the RAM address/write
//            signals.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] ram_rd_addr;
    logic [31:0]       ram_rd_data;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic              ram_wr_en;
    logic [31:0]       ram_wr_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_rd_addr, ram_wr_addr, ram_wr_en, ram_wr_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_rd_addr, ram_wr_addr, ram_wr_en, ram_wr_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for a byte-addressed 32-bit data RAM.
// It accepts one RV32I load or store at a time and handles LB, LH, LW, LBU, LHU, SB, SH and SW.
// The RAM always writes a whole word, so SB and SH are performed as an atomic
// read-modify-write.
// Ports:
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   bus   : request/response handshake and RAM port (slave modport, see mem_access_unit_if)
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input logic              clk,
    input logic              n_rst,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StMerge = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [2:0]        f3_q,    f3_d;
    logic              we_q,    we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q,  word_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic        req_legal;
    logic        req_misaligned;
    logic [31:0] load_ext;
    logic [31:0] merge_mask;

    // Decode the incoming request for the legality and alignment checks.
    always_comb begin
        if (bus.req_we) begin
            req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010);
        end else begin
            req_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                        (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                        (bus.req_funct3 == 3'b101);
        end
        req_misaligned = CHECK_ALIGN &&
                         (((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
    end

    // Load extension. The requested byte or half is always at lane 0 of the read word.
    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{bus.ram_rd_data[7]}}, bus.ram_rd_data[7:0]};
            3'b001:  load_ext = {{16{bus.ram_rd_data[15]}}, bus.ram_rd_data[15:0]};
            3'b100:  load_ext = {24'd0, bus.ram_rd_data[7:0]};
            3'b101:  load_ext = {16'd0, bus.ram_rd_data[15:0]};
            default: load_ext = bus.ram_rd_data;
        endcase
    end

    // SB replaces lane 0 and SH replaces lanes 1:0.
    // The other lanes are written back with their own read values.
    assign merge_mask = (f3_q[1:0] == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    f3_d    = bus.req_funct3;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    word_d  = bus.req_wdata;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (!req_legal || req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (!bus.req_we) begin
                        state_d = StLoad;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StMerge;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_ext;
                state_d = StResp;
            end
            StMerge: begin
                word_d  = (bus.ram_rd_data & ~merge_mask) | (wdata_q & merge_mask);
                state_d = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    // Stores and errors return zero data.
    // rdata_q is cleared at accept, so only a completed load shows data.
    assign bus.rsp_rdata   = ((state_q == StResp) && !we_q) ? rdata_q : 32'd0;
    assign bus.rsp_err     = (state_q == StResp) && err_q;
    // The address is passed through unchanged; the RAM wraps its own byte lanes.
    assign bus.ram_rd_addr = addr_q;
    assign bus.ram_wr_addr = addr_q;
    assign bus.ram_wr_en   = (state_q == StWrite);
    assign bus.ram_wr_data = word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk;
    logic n_rst;
    logic mem_clr;
    int   checks;
    int   errors;
    int   wr_count;

    logic [7:0]  mem [0:65535];
    logic [15:0] ra;

    mem_access_unit_if #(.ADDR_W(16)) bus ();

    mem_access_unit #(
        .ADDR_W     (16),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed RAM model: combinational read, whole-word write, lanes wrap at 64 KiB.
    assign ra = bus.ram_rd_addr;
    assign bus.ram_rd_data = {mem[ra + 16'd3], mem[ra + 16'd2], mem[ra + 16'd1], mem[ra]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'd0;
            wr_count <= 0;
        end else if (bus.ram_wr_en) begin
            mem[bus.ram_wr_addr]         <= bus.ram_wr_data[7:0];
            mem[bus.ram_wr_addr + 16'd1] <= bus.ram_wr_data[15:8];
            mem[bus.ram_wr_addr + 16'd2] <= bus.ram_wr_data[23:16];
            mem[bus.ram_wr_addr + 16'd3] <= bus.ram_wr_data[31:24];
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction with rsp_ready high.
    // lat is the cycle in which rsp_valid is seen, counting the accept edge as cycle 0.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nwr);
        int wr0;
        wr0 = wr_count;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk);
        #1;
        nwr = wr_count - wr0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;

    initial begin
        checks         = 0;
        errors         = 0;
        n_rst          = 1'b1;
        mem_clr        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 16'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
        chk("rst_rd_addr", {16'd0, bus.ram_rd_addr}, 32'd0);
        chk("rst_wr_data", bus.ram_wr_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        n_rst   = 1'b1;

        // Word store, then read back.
        xact(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, rd, er, lat, nwr);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_writes", nwr, 1);
        xact(1'b0, 3'b010, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_writes", nwr, 0);

        // Byte store is a read-modify-write.
        xact(1'b1, 3'b000, 16'h0011, 32'h000000AA, rd, er, lat, nwr);
        chk("sb_lat", lat, 3);
        chk("sb_writes", nwr, 1);
        xact(1'b0, 3'b010, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lw_after_sb", rd, 32'hDEADAAEF);

        // Sub-word loads and their extension.
        xact(1'b0, 3'b000, 16'h0011, 32'd0, rd, er, lat, nwr);
        chk("lb", rd, 32'hFFFFFFAA);
        xact(1'b0, 3'b100, 16'h0011, 32'd0, rd, er, lat, nwr);
        chk("lbu", rd, 32'h000000AA);
        xact(1'b0, 3'b001, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lh", rd, 32'hFFFFAAEF);
        xact(1'b0, 3'b101, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lhu", rd, 32'h0000AAEF);
        xact(1'b0, 3'b000, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lb_pos", rd, 32'hFFFFFFEF);
        xact(1'b0, 3'b000, 16'h0013, 32'd0, rd, er, lat, nwr);
        chk("lb_neg13", rd, 32'hFFFFFFDE);

        // Half-word store.
        xact(1'b1, 3'b001, 16'h0012, 32'h12345678, rd, er, lat, nwr);
        chk("sh_lat", lat, 3);
        chk("sh_writes", nwr, 1);
        xact(1'b0, 3'b010, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("lw_after_sh", rd, 32'h5678AAEF);

        // Error cases: misaligned and illegal funct3.
        xact(1'b0, 3'b010, 16'h0012, 32'd0, rd, er, lat, nwr);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_rdata", rd, 32'd0);
        xact(1'b1, 3'b001, 16'h0013, 32'hFFFFFFFF, rd, er, lat, nwr);
        chk("sh_mis_err", {31'd0, er}, 32'd1);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_writes", nwr, 0);
        xact(1'b0, 3'b011, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("ld_f3_011_err", {31'd0, er}, 32'd1);
        chk("ld_f3_011_lat", lat, 1);
        xact(1'b1, 3'b100, 16'h0010, 32'hFFFFFFFF, rd, er, lat, nwr);
        chk("st_f3_100_err", {31'd0, er}, 32'd1);
        chk("st_f3_100_writes", nwr, 0);
        xact(1'b0, 3'b010, 16'h0010, 32'd0, rd, er, lat, nwr);
        chk("ram_unchanged", rd, 32'h5678AAEF);
        chk("ram_unchanged_err", {31'd0, er}, 32'd0);

        // Address wrap: SB at 0xFFFF writes back bytes 0x0000..0x0002 unchanged.
        xact(1'b1, 3'b010, 16'h0000, 32'h44332211, rd, er, lat, nwr);
        xact(1'b1, 3'b000, 16'hFFFF, 32'h00000099, rd, er, lat, nwr);
        chk("wrap_sb_writes", nwr, 1);
        xact(1'b0, 3'b010, 16'h0000, 32'd0, rd, er, lat, nwr);
        chk("wrap_low_word", rd, 32'h44332211);
        xact(1'b0, 3'b100, 16'hFFFF, 32'd0, rd, er, lat, nwr);
        chk("wrap_lbu", rd, 32'h00000099);
        xact(1'b0, 3'b010, 16'hFFFC, 32'd0, rd, er, lat, nwr);
        chk("wrap_top_word", rd, 32'h99000000);

        // Response back-pressure.
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 16'h0010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", bus.rsp_rdata, 32'h5678AAEF);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset in the middle of an SH read-modify-write.
        nwr = wr_count;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 16'h0020;
        bus.req_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mid_merge_rd_addr", {16'd0, bus.ram_rd_addr}, 32'h00000020);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
        chk("mid_rst_wr_data", bus.ram_wr_data, 32'd0);
        chk("mid_rst_rd_addr", {16'd0, bus.ram_rd_addr}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_write", wr_count - nwr, 0);
        chk("mid_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_ready_after", {31'd0, bus.req_ready}, 32'd1);
        xact(1'b0, 3'b010, 16'h0020, 32'd0, rd, er, lat, nwr);
        chk("mid_rst_ram_clean", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
